// File: rtl/fb_triple_buf_ctrl.sv
// -----------------------------------------------------------------------------
// fb_triple_buf_ctrl
//
// Purpose:
//   Triple-buffer scheduler for the shared frame-buffer BRAM. It hands buffer
//   ownership between the camera write path and the display read path.
//   - The writer fills one buffer.
//   - The reader scans a second buffer.
//   - The third buffer holds the newest complete frame ("ready").
//   The module emits per-side base addresses, which are added to the
//   frame-relative pixel addresses of each path. It also counts frames that
//   were dropped (overwritten before being shown) and frames that were
//   repeated (shown again).
//
// Ports:
//   i_clk       system clock
//   i_rstn      synchronous active-low reset
//   i_wr_sof    1-cycle pulse: writer begins a frame
//   i_wr_eof    1-cycle pulse: writer wrote the last pixel of a frame
//   o_wr_base   base address of the writer's current buffer
//   i_rd_sof    1-cycle pulse: display begins a frame (vsync)
//   o_rd_base   base address of the reader's current buffer
//   o_rd_valid  reader buffer holds a complete frame
//   o_rd_new    1-cycle pulse: reader switched to a fresh frame
//   o_wr_err    sticky: sof seen while the writer was mid-frame
//   o_drop_cnt  frames discarded (saturating)
//   o_rpt_cnt   frames repeated (saturating)
// -----------------------------------------------------------------------------
module fb_triple_buf_ctrl #(
  parameter int FRAME_WORDS = 76800,
  parameter int ADDR_W      = $clog2(3*FRAME_WORDS),
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_sof,
  input  logic              i_wr_eof,
  output logic [ADDR_W-1:0] o_wr_base,
  input  logic              i_rd_sof,
  output logic [ADDR_W-1:0] o_rd_base,
  output logic              o_rd_valid,
  output logic              o_rd_new,
  output logic              o_wr_err,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic [CNT_W-1:0]  o_rpt_cnt
);

  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;

  wr_state_t  r_wr_state;
  logic [1:0] r_wr_idx;
  logic [1:0] r_rd_idx;
  logic [1:0] r_rdy_idx;
  logic       r_rdy_valid;

  logic       w_commit;
  logic       w_drop;
  logic [1:0] w_rdy_mid;       // ready index after the commit, before the reader acts
  logic       w_rdy_valid_mid;
  logic       w_rd_swap;
  logic       w_rd_rpt;
  logic [1:0] w_wr_idx_next;
  logic [1:0] w_rd_idx_next;
  logic [1:0] w_rdy_idx_next;

  // Buffer index to BRAM base address. Index 3 never occurs, because the
  // three indices always stay a permutation of {0,1,2}.
  function automatic logic [ADDR_W-1:0] f_base(input logic [1:0] idx);
    case (idx)
      2'd1:    f_base = ADDR_W'(FRAME_WORDS);
      2'd2:    f_base = ADDR_W'(2*FRAME_WORDS);
      default: f_base = '0;
    endcase
  endfunction

  // The writer commit is resolved first. The reader then sees the
  // post-commit ready buffer. This lets a frame finished on the same edge as
  // vsync go straight to the display.
  always_comb begin
    w_commit        = (r_wr_state == WR_ACTIVE) && i_wr_eof;
    w_drop          = w_commit && r_rdy_valid;
    w_wr_idx_next   = w_commit ? r_rdy_idx : r_wr_idx;
    w_rdy_mid       = w_commit ? r_wr_idx  : r_rdy_idx;
    w_rdy_valid_mid = w_commit || r_rdy_valid;
    w_rd_swap       = i_rd_sof && w_rdy_valid_mid;
    w_rd_rpt        = i_rd_sof && !w_rdy_valid_mid && o_rd_valid;
    w_rd_idx_next   = w_rd_swap ? w_rdy_mid : r_rd_idx;
    w_rdy_idx_next  = w_rd_swap ? r_rd_idx  : w_rdy_mid;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_state  <= WR_IDLE;
      r_wr_idx    <= 2'd0;
      r_rd_idx    <= 2'd1;
      r_rdy_idx   <= 2'd2;
      r_rdy_valid <= 1'b0;
      o_wr_base   <= '0;
      o_rd_base   <= ADDR_W'(FRAME_WORDS);
      o_rd_valid  <= 1'b0;
      o_rd_new    <= 1'b0;
      o_wr_err    <= 1'b0;
      o_drop_cnt  <= '0;
      o_rpt_cnt   <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (i_wr_sof) r_wr_state <= WR_ACTIVE;
        end
        default: begin
          if (i_wr_sof) begin
            // A new sof without an eof aborts the frame. The same buffer is
            // refilled. When eof arrives together with sof, the frame was
            // committed above and this is a clean back-to-back start.
            r_wr_state <= WR_ACTIVE;
            if (!i_wr_eof) o_wr_err <= 1'b1;
          end else if (i_wr_eof) begin
            r_wr_state <= WR_IDLE;
          end
        end
      endcase

      r_wr_idx    <= w_wr_idx_next;
      r_rd_idx    <= w_rd_idx_next;
      r_rdy_idx   <= w_rdy_idx_next;
      r_rdy_valid <= w_rdy_valid_mid && !w_rd_swap;
      o_wr_base   <= f_base(w_wr_idx_next);
      o_rd_base   <= f_base(w_rd_idx_next);
      o_rd_valid  <= o_rd_valid || w_rd_swap;
      o_rd_new    <= w_rd_swap;

      if (w_drop && (o_drop_cnt != {CNT_W{1'b1}})) o_drop_cnt <= o_drop_cnt + 1'b1;
      if (w_rd_rpt && (o_rpt_cnt != {CNT_W{1'b1}})) o_rpt_cnt <= o_rpt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_triple_buf_ctrl.sv
module tb_fb_triple_buf_ctrl;
  localparam int FW = 76800;
  localparam int AW = 18;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_sof = 1'b0, wr_eof = 1'b0, rd_sof = 1'b0;
  logic [AW-1:0] wr_base, rd_base;
  logic          rd_valid, rd_new, wr_err;
  logic [CW-1:0] drop_cnt, rpt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #4 clk = ~clk;

  fb_triple_buf_ctrl #(.FRAME_WORDS(FW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_sof(wr_sof), .i_wr_eof(wr_eof), .o_wr_base(wr_base),
    .i_rd_sof(rd_sof), .o_rd_base(rd_base), .o_rd_valid(rd_valid),
    .o_rd_new(rd_new), .o_wr_err(wr_err),
    .o_drop_cnt(drop_cnt), .o_rpt_cnt(rpt_cnt)
  );

  // One clock: drive the pulses, let the edge take them, sample 1 time unit later.
  task automatic step(input logic ws, input logic we, input logic rs);
    wr_sof = ws; wr_eof = we; rd_sof = rs;
    @(posedge clk); #1;
    wr_sof = 1'b0; wr_eof = 1'b0; rd_sof = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b1);   // pulses during reset must be ignored
    step(1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (wr_base !== 0)  begin n_bad++; $display("FAIL reset_wr_base got=%0d want=0", wr_base); end
    n_cmp++; if (rd_base !== FW) begin n_bad++; $display("FAIL reset_rd_base got=%0d want=%0d", rd_base, FW); end
    n_cmp++; if ({rd_valid, rd_new, wr_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b want=000", {rd_valid, rd_new, wr_err}); end
    n_cmp++; if (drop_cnt !== 0 || rpt_cnt !== 0) begin n_bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", drop_cnt, rpt_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_rd_before_frame();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_cmp++; if (rd_new !== 1'b0) begin n_bad++; $display("FAIL early_rd_new got=%b want=0", rd_new); end
    end
    n_cmp++; if (rd_base !== FW) begin n_bad++; $display("FAIL early_rd_base got=%0d want=%0d", rd_base, FW); end
    n_cmp++; if (rd_valid !== 1'b0 || rpt_cnt !== 0) begin n_bad++; $display("FAIL early_valid_rpt got=%b/%0d want=0/0", rd_valid, rpt_cnt); end
    $display("test_rd_before_frame done");
  endtask

  task automatic test_single_frame();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (wr_base !== 0) begin n_bad++; $display("FAIL single_wr_base0 got=%0d want=0", wr_base); end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (wr_base !== 2*FW) begin n_bad++; $display("FAIL single_wr_base1 got=%0d want=%0d", wr_base, 2*FW); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (rd_base !== 0) begin n_bad++; $display("FAIL single_rd_base got=%0d want=0", rd_base); end
    n_cmp++; if (rd_new !== 1'b1 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL single_new_valid got=%b%b want=11", rd_new, rd_valid); end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (rd_new !== 1'b0) begin n_bad++; $display("FAIL single_new_pulse got=%b want=0", rd_new); end
    $display("test_single_frame done");
  endtask

  // Three frames complete before vsync: two are lost, the display gets the last.
  task automatic test_drops_then_repeat();
    logic [AW-1:0] third_buf, shown;
    do_reset();
    third_buf = '0;
    for (int f = 0; f < 3; f++) begin
      step(1'b1, 1'b0, 1'b0);
      third_buf = wr_base;
      step(1'b0, 1'b1, 1'b0);
    end
    n_cmp++; if (drop_cnt !== 2) begin n_bad++; $display("FAIL drops_cnt got=%0d want=2", drop_cnt); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (rd_base !== third_buf) begin n_bad++; $display("FAIL drops_rd_base got=%0d want=%0d", rd_base, third_buf); end
    shown = rd_base;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (rpt_cnt !== 3) begin n_bad++; $display("FAIL repeat_cnt got=%0d want=3", rpt_cnt); end
    n_cmp++; if (rd_base !== shown) begin n_bad++; $display("FAIL repeat_rd_base got=%0d want=%0d", rd_base, shown); end
    $display("test_drops_then_repeat done");
  endtask

  // Commit and vsync on the same edge, with a frame already pending.
  task automatic test_coincide();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);   // W=2 R=1 Y=0, ready valid
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_cmp++; if (wr_base !== 0) begin n_bad++; $display("FAIL coincide_wr_base got=%0d want=0", wr_base); end
    n_cmp++; if (rd_base !== 2*FW) begin n_bad++; $display("FAIL coincide_rd_base got=%0d want=%0d", rd_base, 2*FW); end
    n_cmp++; if (drop_cnt !== 1 || rd_new !== 1'b1) begin n_bad++; $display("FAIL coincide_drop_new got=%0d/%b want=1/1", drop_cnt, rd_new); end
    $display("test_coincide done");
  endtask

  task automatic test_wr_err_and_midreset();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (wr_err !== 1'b1 || wr_base !== 0) begin n_bad++; $display("FAIL err_set got=%b/%0d want=1/0", wr_err, wr_base); end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);   // eof while idle: ignored
    n_cmp++; if (wr_base !== 2*FW || drop_cnt !== 0) begin n_bad++; $display("FAIL err_one_commit got=%0d/%0d want=%0d/0", wr_base, drop_cnt, 2*FW); end
    step(1'b1, 1'b0, 1'b1);
    rstn = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    n_cmp++; if (wr_base !== 0 || rd_base !== FW) begin n_bad++; $display("FAIL midreset_bases got=%0d/%0d want=0/%0d", wr_base, rd_base, FW); end
    n_cmp++; if ({rd_valid, rd_new, wr_err} !== 3'b000 || drop_cnt !== 0 || rpt_cnt !== 0) begin
      n_bad++; $display("FAIL midreset_state got=%b/%0d/%0d want=000/0/0", {rd_valid, rd_new, wr_err}, drop_cnt, rpt_cnt);
    end
    rstn = 1'b1;
    $display("test_wr_err_and_midreset done");
  endtask

  // Random traffic against a role model. Each buffer carries the serial of
  // the frame stored in it. The display must always show the newest
  // complete frame. Drops are derived from the count balance:
  // commits = shown + dropped + pending.
  task automatic test_random();
    int role_wr, role_rd, role_rdy, tmp;
    int serial[3];
    int commits, shown, rpts, last_done;
    bit active, pending, displayed, err, fresh;
    logic ws, we, rs, rn;
    int exp_drop;
    do_reset();
    role_wr = 0; role_rd = 1; role_rdy = 2; serial = '{-1, -1, -1};
    commits = 0; shown = 0; rpts = 0; last_done = -1;
    active = 0; pending = 0; displayed = 0; err = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      ws = ($urandom_range(0, 9) == 0);
      we = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 799) != 0);
      rstn = rn;
      step(ws, we, rs);
      fresh = 0;
      if (!rn) begin
        role_wr = 0; role_rd = 1; role_rdy = 2; serial = '{-1, -1, -1};
        commits = 0; shown = 0; rpts = 0; last_done = -1;
        active = 0; pending = 0; displayed = 0; err = 0;
      end else begin
        if (active && we) begin
          serial[role_wr] = commits; last_done = commits; commits++;
          tmp = role_wr; role_wr = role_rdy; role_rdy = tmp; pending = 1;
        end
        if (active && ws && !we) err = 1;
        if (ws) active = 1; else if (we) active = 0;
        if (rs) begin
          if (pending) begin
            tmp = role_rd; role_rd = role_rdy; role_rdy = tmp;
            pending = 0; displayed = 1; fresh = 1; shown++;
          end else if (displayed) rpts++;
        end
      end
      rstn = 1'b1;
      exp_drop = commits - shown - (pending ? 1 : 0);
      n_cmp++;
      if (wr_base !== AW'(role_wr*FW) || rd_base !== AW'(role_rd*FW)) begin
        n_bad++; $display("FAIL rand_bases cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, wr_base, rd_base, role_wr*FW, role_rd*FW);
      end
      n_cmp++;
      if ({rd_valid, rd_new, wr_err} !== {displayed, fresh, err}) begin
        n_bad++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", cyc, {rd_valid, rd_new, wr_err}, {displayed, fresh, err});
      end
      n_cmp++;
      if (drop_cnt !== CW'(exp_drop) || rpt_cnt !== CW'(rpts)) begin
        n_bad++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, drop_cnt, rpt_cnt, exp_drop, rpts);
      end
      if (fresh) begin
        n_cmp++;
        if (serial[rd_base / FW] != last_done) begin
          n_bad++; $display("FAIL rand_newest cyc=%0d got_serial=%0d want=%0d", cyc, serial[rd_base / FW], last_done);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_rd_before_frame();
    test_single_frame();
    test_drops_then_repeat();
    test_coincide();
    test_wr_err_and_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
